fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_buf.sv | 80 ++++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, IF/ID bus width,
// state encoding and PC increment helper.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam int          IF_ID_BUS_W      = 64;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FETCH       = 2'd1,
    CANCEL_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// In-order fetch buffer: entries are allocated at request acceptance and filled
// oldest-first as responses return; the head is popped toward ID.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [31:0]              alloc_pc,
  input  logic                     fill,
  input  logic [31:0]              fill_inst,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     head_filled,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]    pc_mem   [DEPTH];
  logic [31:0]    inst_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  fill_ptr;
  logic [PW-1:0]  rd_ptr;

  // Pointers, occupancy and per-entry filled flags; a flush empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      filled   <= '0;
    end else begin
      if (alloc) begin
        wr_ptr         <= wr_ptr + 1'b1;
        filled[wr_ptr] <= 1'b0;
      end
      if (fill) begin
        fill_ptr         <= fill_ptr + 1'b1;
        filled[fill_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count + CW'(alloc) - CW'(pop);
      pending <= pending + CW'(alloc) - CW'(fill);
    end
  end

  // Entry payload; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= 32'h0;
        inst_mem[i] <= 32'h0;
      end
    end else begin
      if (alloc) begin
        pc_mem[wr_ptr] <= alloc_pc;
      end
      if (fill) begin
        inst_mem[fill_ptr] <= fill_inst;
      end
    end
  end

  assign head_filled = (count != '0) && filled[rd_ptr];
  assign head_pc     = pc_mem[rd_ptr];
  assign head_inst   = inst_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers in-order responses
// for ID, and discards responses belonging to requests cancelled by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_allow_in,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [31:0]            inst_rdata,
  output logic                   if_to_id_valid,
  output logic [IF_ID_BUS_W-1:0] if_to_id_bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic [CW-1:0] cancel_cnt;
  logic [CW-1:0] cancel_next;
  logic [CW-1:0] count;
  logic [CW-1:0] pending;
  logic [CW-1:0] used;
  logic          accept;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;
  logic          head_filled;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;

  // A slot freed by this cycle's pop may be reallocated at once, keeping one fetch per cycle.
  assign pop            = if_to_id_valid && id_allow_in;
  assign used           = count - CW'(pop);
  assign inst_req       = (state == FETCH) && (used < CW'(BUF_DEPTH)) && !redirect_valid;
  assign inst_addr      = fetch_pc;
  assign accept         = inst_req && inst_addr_ok;
  assign resp_drop      = inst_data_ok && (cancel_cnt != '0);
  assign resp_fill      = inst_data_ok && (cancel_cnt == '0) && (pending != '0);
  assign if_to_id_valid = head_filled && !redirect_valid && (state != CANCEL_WAIT);
  assign if_to_id_bus   = {head_pc, head_inst};

  // Outstanding requests still owed by memory after this cycle, if a redirect cancels them.
  always_comb begin
    cancel_next = cancel_cnt - CW'(resp_drop);
    if (redirect_valid) begin
      cancel_next = cancel_next + pending + CW'(accept) - CW'(resp_fill);
    end else begin
      cancel_next = cancel_next;
    end
  end

  // Fetch control state, next fetch address and cancel counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      cancel_cnt <= '0;
    end else begin
      cancel_cnt <= cancel_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
      end else if (accept) begin
        fetch_pc <= next_pc(fetch_pc);
      end
      case (state)
        IDLE:        state <= FETCH;
        FETCH:       if (redirect_valid && (cancel_next != '0)) state <= CANCEL_WAIT;
        CANCEL_WAIT: if (cancel_next == '0) state <= FETCH;
        default:     state <= IDLE;
      endcase
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect_valid),
    .alloc       (accept),
    .alloc_pc    (fetch_pc),
    .fill        (resp_fill),
    .fill_inst   (inst_rdata),
    .pop         (pop),
    .count       (count),
    .pending     (pending),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_inst   (head_inst)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors for streaming and
// stall behaviour, then hand sequences for redirects, PC wrap and reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_allow_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .id_allow_in     (id_allow_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_bus    (if_to_id_bus)
  );

  typedef struct {
    logic        rst;
    logic        id;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [63:0] e_bus;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, then caller checks.
  task automatic cyc(input logic rst, input logic id, input logic rv, input logic [31:0] rt,
                     input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    reset           = rst;
    id_allow_in     = id;
    redirect_valid  = rv;
    redirect_target = rt;
    inst_addr_ok    = aok;
    inst_data_ok    = dok;
    inst_rdata      = rd;
    #1;
  endtask

  localparam logic [31:0] P0 = 32'h1c000000, P1 = 32'h1c000004, P2 = 32'h1c000008;
  localparam logic [31:0] P3 = 32'h1c00000c, P4 = 32'h1c000010, P5 = 32'h1c000014;
  localparam logic [31:0] P6 = 32'h1c000018, P7 = 32'h1c00001c, P8 = 32'h1c000020;
  localparam logic [31:0] D0 = 32'h465a5a5a, D1 = 32'h465a5a5e, D2 = 32'h465a5a52;
  localparam logic [31:0] D3 = 32'h465a5a56, D4 = 32'h465a5a4a, D5 = 32'h465a5a4e;
  localparam logic [31:0] D6 = 32'h465a5a42, D7 = 32'h465a5a46;

  initial begin
    reset = 1'b1; id_allow_in = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    repeat (2) @(posedge clk);

    //          rst   id    aok   dok   rdata  req   addr  valid bus
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, P0, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, P0, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, P0, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, D0,    1'b1, P1, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, D1,    1'b1, P2, 1'b1, {P0, D0}};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, D2,    1'b1, P3, 1'b1, {P1, D1}};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, D3,    1'b1, P4, 1'b1, {P2, D2}};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, D4,    1'b0, P5, 1'b1, {P3, D3}};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, P5, 1'b1, {P3, D3}};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, P5, 1'b1, {P3, D3}};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, P5, 1'b1, {P3, D3}};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, P5, 1'b1, {P3, D3}};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, P5, 1'b1, {P3, D3}};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, D5,    1'b1, P6, 1'b1, {P4, D4}};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, D6,    1'b1, P7, 1'b1, {P5, D5}};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, D7,    1'b0, P8, 1'b1, {P6, D6}};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, P8, 1'b1, {P6, D6}};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, P8, 1'b1, {P7, D7}};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, P8, 1'b0, 64'h0};

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].rst, vecs[i].id, 1'b0, 32'h0, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
      chk($sformatf("v%0d_req", i), 64'(inst_req), 64'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i), 64'(inst_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d_valid", i), 64'(if_to_id_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid || vecs[i].rst) begin
        chk($sformatf("v%0d_bus", i), if_to_id_bus, vecs[i].e_bus);
      end
    end

    // Two outstanding requests cancelled by a redirect.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("a1_addr", 64'(inst_addr), 64'(P8));
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("a2_addr", 64'(inst_addr), 64'h1c000024);
    cyc(1'b0, 1'b1, 1'b1, 32'h1c000100, 1'b1, 1'b0, 32'h0);
    chk("a3_req", 64'(inst_req), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hdeadbeef);
    chk("a4_cancel", 64'(dut.cancel_cnt), 64'd2);
    chk("a4_req", 64'(inst_req), 64'h0);
    chk("a4_valid", 64'(if_to_id_valid), 64'h0);
    chk("a4_addr", 64'(inst_addr), 64'h1c000100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hcafef00d);
    chk("a5_cancel", 64'(dut.cancel_cnt), 64'd1);
    chk("a5_valid", 64'(if_to_id_valid), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("a6_cancel", 64'(dut.cancel_cnt), 64'd0);
    chk("a6_req", 64'(inst_req), 64'h1);
    chk("a6_addr", 64'(inst_addr), 64'h1c000100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h465a5b5a);
    chk("a7_valid", 64'(if_to_id_valid), 64'h0);
    chk("a7_addr", 64'(inst_addr), 64'h1c000104);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("a8_valid", 64'(if_to_id_valid), 64'h1);
    chk("a8_bus", if_to_id_bus, 64'h1c000100_465a5b5a);

    // Redirect coinciding with a response: one of two outstanding remains to cancel.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("b1_addr", 64'(inst_addr), 64'h1c000104);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("b2_req", 64'(inst_req), 64'h1);
    cyc(1'b0, 1'b1, 1'b1, 32'h1c000200, 1'b1, 1'b1, 32'h11111111);
    chk("b3_req", 64'(inst_req), 64'h0);
    chk("b3_valid", 64'(if_to_id_valid), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("b4_cancel", 64'(dut.cancel_cnt), 64'd1);
    chk("b4_req", 64'(inst_req), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22222222);
    chk("b5_req", 64'(inst_req), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("b6_cancel", 64'(dut.cancel_cnt), 64'd0);
    chk("b6_req", 64'(inst_req), 64'h1);
    chk("b6_addr", 64'(inst_addr), 64'h1c000200);
    chk("b6_valid", 64'(if_to_id_valid), 64'h0);

    // Zero-outstanding redirect, then PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 1'b1, 32'hfffffffc, 1'b1, 1'b0, 32'h0);
    chk("c1_req", 64'(inst_req), 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("c2_req", 64'(inst_req), 64'h1);
    chk("c2_addr", 64'(inst_addr), 64'hfffffffc);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("c3_addr", 64'(inst_addr), 64'h00000000);

    // Reset while waiting on a cancelled response.
    cyc(1'b0, 1'b1, 1'b1, 32'h1c000300, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("d1_cancel", 64'(dut.cancel_cnt), 64'd1);
    chk("d1_state", 64'(dut.state), 64'(CANCEL_WAIT));
    chk("d1_addr", 64'(inst_addr), 64'h1c000300);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("d2_state", 64'(dut.state), 64'(IDLE));
    chk("d2_count", 64'(dut.u_buf.count), 64'd0);
    chk("d2_cancel", 64'(dut.cancel_cnt), 64'd0);
    chk("d2_addr", 64'(inst_addr), 64'(P0));
    chk("d2_req", 64'(inst_req), 64'h0);
    chk("d2_valid", 64'(if_to_id_valid), 64'h0);
    chk("d2_bus", if_to_id_bus, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
